// File: rtl/bank_isu_credit_arb.sv
// Credit-gated round-robin issue arbiter for three ISU channels feeding the SC/xbar port.
// Optional per-channel stall counters are enabled with `define ISU_ARB_STALL_CNT_EN.
module bank_isu_credit_arb #(
    parameter int NUM_CH      = 3,
    parameter int PAYLOAD_W   = 150,
    parameter int CREDIT_W    = 3,
    parameter int INIT_CREDIT = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_CH-1:0]             req_valid_i,
    output logic [NUM_CH-1:0]             req_ready_o,
    input  logic [NUM_CH*PAYLOAD_W-1:0]   req_payload_i,
    input  logic [NUM_CH-1:0]             credit_return_i,
    output logic                          issue_valid_o,
    input  logic                          issue_ready_i,
    output logic [1:0]                    issue_ch_id_o,
    output logic [PAYLOAD_W-1:0]          issue_payload_o,
    output logic [NUM_CH*CREDIT_W-1:0]    credit_cnt_o,
`ifdef ISU_ARB_STALL_CNT_EN
    output logic [NUM_CH*16-1:0]          stall_cnt_o,
`endif
    output logic                          credit_err_o
);

    localparam logic [CREDIT_W-1:0] CREDIT_MAX  = {CREDIT_W{1'b1}};
    localparam logic [CREDIT_W-1:0] CREDIT_INIT = CREDIT_W'(INIT_CREDIT);

    // Modulo-3 ring step used by the round-robin search.
    function automatic logic [1:0] ring_add(input logic [1:0] base, input logic [1:0] step);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, step};
        if (sum >= 3'd3) begin
            return 2'(sum - 3'd3);
        end else begin
            return sum[1:0];
        end
    endfunction

    logic [1:0]                 last_gnt_q, last_gnt_d;
    logic [NUM_CH*CREDIT_W-1:0] credit_q, credit_d;
    logic                       credit_err_q, credit_err_d;
    logic                       issue_valid_q, issue_valid_d;
    logic [1:0]                 issue_ch_id_q, issue_ch_id_d;
    logic [PAYLOAD_W-1:0]       issue_payload_q, issue_payload_d;
    logic [NUM_CH-1:0]          eligible_s, grant_s;
    logic [1:0]                 gnt_idx_s, cand_s;
    logic                       gnt_any_s, slot_free_s;

    // Eligibility and round-robin grant starting after the last granted channel.
    always_comb begin
        eligible_s  = '0;
        grant_s     = '0;
        gnt_idx_s   = 2'd0;
        gnt_any_s   = 1'b0;
        cand_s      = 2'd0;
        slot_free_s = ~issue_valid_q | issue_ready_i;
        for (int i = 0; i < NUM_CH; i++) begin
            eligible_s[i] = req_valid_i[i] & (credit_q[i*CREDIT_W +: CREDIT_W] != '0);
        end
        for (int k = 1; k <= NUM_CH; k++) begin
            cand_s = ring_add(last_gnt_q, 2'(k));
            if (!gnt_any_s && slot_free_s && !rst_i && eligible_s[cand_s]) begin
                gnt_any_s       = 1'b1;
                gnt_idx_s       = cand_s;
                grant_s[cand_s] = 1'b1;
            end else begin
                gnt_any_s = gnt_any_s;
            end
        end
    end

    // Credit counters: a return at the maximum is dropped and flagged.
    always_comb begin
        credit_d     = credit_q;
        credit_err_d = credit_err_q;
        for (int i = 0; i < NUM_CH; i++) begin
            case ({credit_return_i[i], grant_s[i]})
                2'b10: begin
                    if (credit_q[i*CREDIT_W +: CREDIT_W] != CREDIT_MAX) begin
                        credit_d[i*CREDIT_W +: CREDIT_W] = credit_q[i*CREDIT_W +: CREDIT_W] + {{(CREDIT_W-1){1'b0}}, 1'b1};
                    end else begin
                        credit_err_d = 1'b1;
                    end
                end
                2'b01: credit_d[i*CREDIT_W +: CREDIT_W] = credit_q[i*CREDIT_W +: CREDIT_W] - {{(CREDIT_W-1){1'b0}}, 1'b1};
                2'b11: begin
                    if (credit_q[i*CREDIT_W +: CREDIT_W] == CREDIT_MAX) begin
                        credit_err_d = 1'b1;
                    end else begin
                        credit_err_d = credit_err_d;
                    end
                end
                default: credit_d[i*CREDIT_W +: CREDIT_W] = credit_q[i*CREDIT_W +: CREDIT_W];
            endcase
        end
    end

    // Output slot: load on grant, drain on handshake, otherwise hold.
    always_comb begin
        issue_valid_d   = issue_valid_q;
        issue_ch_id_d   = issue_ch_id_q;
        issue_payload_d = issue_payload_q;
        last_gnt_d      = last_gnt_q;
        if (gnt_any_s) begin
            issue_valid_d   = 1'b1;
            issue_ch_id_d   = gnt_idx_s;
            issue_payload_d = req_payload_i[gnt_idx_s*PAYLOAD_W +: PAYLOAD_W];
            last_gnt_d      = gnt_idx_s;
        end else if (issue_valid_q && issue_ready_i) begin
            issue_valid_d = 1'b0;
        end else begin
            issue_valid_d = issue_valid_q;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_gnt_q      <= 2'd2;
            credit_q        <= {NUM_CH{CREDIT_INIT}};
            credit_err_q    <= 1'b0;
            issue_valid_q   <= 1'b0;
            issue_ch_id_q   <= 2'd0;
            issue_payload_q <= '0;
        end else begin
            last_gnt_q      <= last_gnt_d;
            credit_q        <= credit_d;
            credit_err_q    <= credit_err_d;
            issue_valid_q   <= issue_valid_d;
            issue_ch_id_q   <= issue_ch_id_d;
            issue_payload_q <= issue_payload_d;
        end
    end

`ifdef ISU_ARB_STALL_CNT_EN
    logic [NUM_CH*16-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles each channel waited with a pending request.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (req_valid_i[i] && !grant_s[i] && (stall_cnt_q[i*16 +: 16] != 16'hFFFF)) begin
                stall_cnt_d[i*16 +: 16] = stall_cnt_q[i*16 +: 16] + 16'd1;
            end else begin
                stall_cnt_d[i*16 +: 16] = stall_cnt_q[i*16 +: 16];
            end
        end
    end

    // Stall counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

    assign req_ready_o     = grant_s;
    assign issue_valid_o   = issue_valid_q;
    assign issue_ch_id_o   = issue_ch_id_q;
    assign issue_payload_o = issue_payload_q;
    assign credit_cnt_o    = credit_q;
    assign credit_err_o    = credit_err_q;

endmodule
